// File: rtl/bram2_be_srv.sv
// Dual-port byte-enable block RAM with credit-limited response FIFOs.
// Each port accepts one request per cycle; reads return data through a FIFO.
module bram2_be_srv_port #(
  parameter int DW   = 64,
  parameter int NB   = 8,
  parameter int PIPE = 0,
  parameter int WF   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [NB-1:0] we,
  input  logic [DW-1:0] rdat,
  input  logic          deq,
  output logic          rdy,
  output logic          acc,
  output logic [DW-1:0] dout,
  output logic          dv
);
  localparam int LAT   = 1 + PIPE;
  localparam int DEPTH = LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          run;
  logic [CW-1:0] credit;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [DW-1:0] fifo [DEPTH];
  logic          wr;
  logic          echo;
  logic          resp;
  logic          push;
  logic          pop;
  logic [DW-1:0] pdata;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // a full-word write echoes its data back only in write-first mode
  assign wr   = |we;
  assign echo = (WF != 0) && (&we);
  assign rdy  = run && ((credit != '0) || (wr && !echo));
  assign acc  = en && rdy;
  assign resp = acc && (!wr || echo);
  assign dv   = cnt != '0;
  assign pop  = deq && dv;
  assign dout = dv ? fifo[rp] : '0;

  generate
    if (PIPE != 0) begin : g_pipe
      logic          pv;
      logic [DW-1:0] pd;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pv <= 1'b0;
        else     pv <= resp;
      end
      always_ff @(posedge clk) begin
        if (resp) pd <= rdat;
      end
      assign push  = pv;
      assign pdata = pd;
    end else begin : g_flow
      assign push  = resp;
      assign pdata = rdat;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      credit <= CW'(DEPTH);
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
    end else begin
      run    <= 1'b1;
      credit <= credit - CW'(resp) + CW'(pop);
      cnt    <= cnt + CW'(push) - CW'(pop);
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= pdata;
    if (!rst) assert (!(push && !pop && cnt == CW'(DEPTH)));
  end
endmodule

module bram2_be_srv #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int BYTE_WIDTH  = 8,
  parameter int MEMSIZE     = 1024,
  parameter int PIPELINED   = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ENA,
  output logic                             RDYA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEA,
  input  logic [ADDR_WIDTH-1:0]            ADDRA,
  input  logic [DATA_WIDTH-1:0]            DIA,
  output logic [DATA_WIDTH-1:0]            DOA,
  output logic                             DVA,
  input  logic                             DEQA,
  input  logic                             ENB,
  output logic                             RDYB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEB,
  input  logic [ADDR_WIDTH-1:0]            ADDRB,
  input  logic [DATA_WIDTH-1:0]            DIB,
  output logic [DATA_WIDTH-1:0]            DOB,
  output logic                             DVB,
  input  logic                             DEQB
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int BW = BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEMSIZE];
  logic                  ok_a;
  logic                  ok_b;
  logic                  acc_a;
  logic                  acc_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign ok_a = {1'b0, ADDRA} < (ADDR_WIDTH + 1)'(MEMSIZE);
  assign ok_b = {1'b0, ADDRB} < (ADDR_WIDTH + 1)'(MEMSIZE);

  // writes feed their own data so write-first echoes the new word
  assign rd_a = (|WEA) ? DIA : (ok_a ? mem[ADDRA] : '0);
  assign rd_b = (|WEB) ? DIB : (ok_b ? mem[ADDRB] : '0);

  // port A is applied last so it owns colliding bytes
  always_ff @(posedge CLK) begin
    if (acc_b && ok_b) begin
      for (int i = 0; i < NB; i++)
        if (WEB[i]) mem[ADDRB][i*BW +: BW] <= DIB[i*BW +: BW];
    end
    if (acc_a && ok_a) begin
      for (int i = 0; i < NB; i++)
        if (WEA[i]) mem[ADDRA][i*BW +: BW] <= DIA[i*BW +: BW];
    end
  end

  bram2_be_srv_port #(
    .DW(DATA_WIDTH), .NB(NB), .PIPE(PIPELINED), .WF(WRITE_FIRST)
  ) u_pa (
    .clk(CLK), .rst(RST), .en(ENA), .we(WEA), .rdat(rd_a),
    .deq(DEQA), .rdy(RDYA), .acc(acc_a), .dout(DOA), .dv(DVA)
  );

  bram2_be_srv_port #(
    .DW(DATA_WIDTH), .NB(NB), .PIPE(PIPELINED), .WF(WRITE_FIRST)
  ) u_pb (
    .clk(CLK), .rst(RST), .en(ENB), .we(WEB), .rdat(rd_b),
    .deq(DEQB), .rdy(RDYB), .acc(acc_b), .dout(DOB), .dv(DVB)
  );
endmodule

// File: tb/tb_bram2_be_srv.sv
// Directed bench for bram2_be_srv: flow-through, pipelined and
// write-first instances driven with hand-computed vectors.
module tb_bram2_be_srv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic en_a0, rdy_a0, dv_a0, deq_a0, en_b0, rdy_b0, dv_b0, deq_b0;
  logic [7:0] we_a0, we_b0;
  logic [9:0] addr_a0, addr_b0;
  logic [63:0] di_a0, di_b0, do_a0, do_b0;

  logic en_a1, rdy_a1, dv_a1, deq_a1, en_b1, rdy_b1, dv_b1, deq_b1;
  logic [7:0] we_a1, we_b1;
  logic [9:0] addr_a1, addr_b1;
  logic [63:0] di_a1, di_b1, do_a1, do_b1;

  logic en_a2, rdy_a2, dv_a2, deq_a2, en_b2, rdy_b2, dv_b2, deq_b2;
  logic [7:0] we_a2, we_b2;
  logic [9:0] addr_a2, addr_b2;
  logic [63:0] di_a2, di_b2, do_a2, do_b2;

  int checks = 0;
  int errors = 0;
  int nacc;
  int drops;

  bram2_be_srv #(.MEMSIZE(1000), .PIPELINED(0), .WRITE_FIRST(0)) u0 (
    .CLK(clk), .RST(rst),
    .ENA(en_a0), .RDYA(rdy_a0), .WEA(we_a0), .ADDRA(addr_a0), .DIA(di_a0),
    .DOA(do_a0), .DVA(dv_a0), .DEQA(deq_a0),
    .ENB(en_b0), .RDYB(rdy_b0), .WEB(we_b0), .ADDRB(addr_b0), .DIB(di_b0),
    .DOB(do_b0), .DVB(dv_b0), .DEQB(deq_b0)
  );

  bram2_be_srv #(.PIPELINED(1), .WRITE_FIRST(0)) u1 (
    .CLK(clk), .RST(rst),
    .ENA(en_a1), .RDYA(rdy_a1), .WEA(we_a1), .ADDRA(addr_a1), .DIA(di_a1),
    .DOA(do_a1), .DVA(dv_a1), .DEQA(deq_a1),
    .ENB(en_b1), .RDYB(rdy_b1), .WEB(we_b1), .ADDRB(addr_b1), .DIB(di_b1),
    .DOB(do_b1), .DVB(dv_b1), .DEQB(deq_b1)
  );

  bram2_be_srv #(.PIPELINED(0), .WRITE_FIRST(1)) u2 (
    .CLK(clk), .RST(rst),
    .ENA(en_a2), .RDYA(rdy_a2), .WEA(we_a2), .ADDRA(addr_a2), .DIA(di_a2),
    .DOA(do_a2), .DVA(dv_a2), .DEQA(deq_a2),
    .ENB(en_b2), .RDYB(rdy_b2), .WEB(we_b2), .ADDRB(addr_b2), .DIB(di_b2),
    .DOB(do_b2), .DVB(dv_b2), .DEQB(deq_b2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {en_a0, deq_a0, en_b0, deq_b0} = '0;
    {en_a1, deq_a1, en_b1, deq_b1} = '0;
    {en_a2, deq_a2, en_b2, deq_b2} = '0;
    {we_a0, we_b0, we_a1, we_b1, we_a2, we_b2} = '0;
    {addr_a0, addr_b0, addr_a1, addr_b1, addr_a2, addr_b2} = '0;
    {di_a0, di_b0, di_a1, di_b1, di_a2, di_b2} = '0;
    repeat (2) step();
    chk("rst_rdy", rdy_a0, 0);
    chk("rst_dv", dv_a0, 0);
    chk("rst_do", do_a0, 0);
    rst = 1'b0;
    step();
    chk("idle_rdya", rdy_a0, 1);
    chk("idle_rdyb", rdy_b0, 1);
    chk("idle_rdya1", rdy_a1, 1);
    chk("idle_rdyb1", rdy_b1, 1);
    chk("idle_dva", dv_a0, 0);
    chk("idle_dvb", dv_b0, 0);
    chk("idle_doa", do_a0, 0);
    chk("idle_dob", do_b0, 0);

    en_a0 = 1; we_a0 = 8'hFF; addr_a0 = 5; di_a0 = 64'h1122334455667788;
    step();
    we_a0 = 8'h00;
    chk("wr_noresp", dv_a0, 0);
    step();
    en_a0 = 0;
    chk("rd_dv", dv_a0, 1);
    chk("rd_do", do_a0, 64'h1122334455667788);
    deq_a0 = 1;
    step();
    deq_a0 = 0;
    chk("deq_dv", dv_a0, 0);
    chk("deq_do", do_a0, 0);

    en_a0 = 1; we_a0 = 8'h0F; di_a0 = '1;
    step();
    we_a0 = 8'h00;
    step();
    en_a0 = 0;
    chk("be_do", do_a0, 64'h11223344FFFFFFFF);
    deq_a0 = 1;
    step();
    deq_a0 = 0;

    en_a0 = 1; we_a0 = 8'hF0; addr_a0 = 9; di_a0 = 64'hAAAAAAAAAAAAAAAA;
    en_b0 = 1; we_b0 = 8'hFF; addr_b0 = 9; di_b0 = 64'h5555555555555555;
    step();
    en_b0 = 0; we_a0 = 8'h00;
    step();
    en_a0 = 0;
    chk("coll_ww", do_a0, 64'hAAAAAAAA55555555);
    deq_a0 = 1;
    step();
    deq_a0 = 0;

    en_a0 = 1; we_a0 = 8'hFF; di_a0 = 64'h0123456789ABCDEF;
    en_b0 = 1; we_b0 = 8'h00;
    step();
    en_a0 = 0;
    chk("coll_rw_dv", dv_b0, 1);
    chk("coll_rw_old", do_b0, 64'hAAAAAAAA55555555);
    deq_b0 = 1;
    step();
    en_b0 = 0;
    chk("rw_new", do_b0, 64'h0123456789ABCDEF);
    step();
    deq_b0 = 0;
    chk("rw_drain", dv_b0, 0);

    en_a0 = 1; we_a0 = 8'h00; addr_a0 = 10'd1000;
    en_b0 = 1; we_b0 = 8'hFF; addr_b0 = 10'd1000; di_b0 = '1;
    step();
    en_a0 = 0; en_b0 = 0;
    chk("oor_dv", dv_a0, 1);
    chk("oor_do", do_a0, 0);
    deq_a0 = 1;
    step();
    deq_a0 = 0;

    en_a2 = 1; we_a2 = 8'hFF; addr_a2 = 7; di_a2 = 64'hCAFEF00DDEADBEEF;
    step();
    en_a2 = 0;
    chk("wf_dv", dv_a2, 1);
    chk("wf_do", do_a2, 64'hCAFEF00DDEADBEEF);
    deq_a2 = 1;
    step();
    deq_a2 = 0;
    en_a2 = 1; we_a2 = 8'h0F; di_a2 = '0;
    step();
    chk("wf_part", dv_a2, 0);
    we_a2 = 8'h00;
    step();
    en_a2 = 0;
    chk("wf_rd", do_a2, 64'hCAFEF00D00000000);
    deq_a2 = 1;
    step();
    deq_a2 = 0;

    for (int k = 0; k < 5; k++) begin
      en_a1 = 1; we_a1 = 8'hFF; addr_a1 = 10'(20 + k);
      di_a1 = 64'hD000 + 64'(20 + k);
      step();
    end
    we_a1 = 8'h00;
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      addr_a1 = 10'(20 + k);
      if (rdy_a1) nacc++;
      step();
    end
    en_a1 = 0;
    chk("bp_nacc", 64'(nacc), 3);
    chk("bp_rdy", rdy_a1, 0);
    chk("bp_dv", dv_a1, 1);
    chk("bp_do0", do_a1, 64'hD014);
    deq_a1 = 1;
    step();
    chk("bp_rdy_back", rdy_a1, 1);
    chk("bp_do1", do_a1, 64'hD015);
    step();
    chk("bp_do2", do_a1, 64'hD016);
    step();
    deq_a1 = 0;
    chk("bp_empty", dv_a1, 0);

    deq_b1 = 1; we_b1 = 8'h00; drops = 0;
    for (int c = 0; c < 102; c++) begin
      if (c < 2) begin
        chk("st_lat", dv_b1, 0);
      end else begin
        chk("st_dv", dv_b1, 1);
        chk("st_do", do_b1, 64'hD000 + 64'(20 + (c - 2) % 5));
      end
      if (c < 100) begin
        en_b1 = 1; addr_b1 = 10'(20 + c % 5);
        if (!rdy_b1) drops++;
      end else begin
        en_b1 = 0;
      end
      step();
    end
    chk("st_drops", 64'(drops), 0);
    chk("st_done", dv_b1, 0);
    deq_b1 = 0;

    en_a1 = 1; addr_a1 = 20;
    step();
    addr_a1 = 21;
    step();
    en_a1 = 0;
    step();
    chk("mr_dv", dv_a1, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_dv0", dv_a1, 0);
    chk("mr_do0", do_a1, 0);
    chk("mr_rdy0", rdy_a1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("mr_rdy1", rdy_a1, 1);
    nacc = 0;
    en_a1 = 1;
    for (int k = 0; k < 4; k++) begin
      addr_a1 = 10'(20 + k);
      if (rdy_a1) nacc++;
      step();
    end
    en_a1 = 0;
    chk("mr_credits", 64'(nacc), 3);
    deq_a1 = 1;
    repeat (4) step();
    deq_a1 = 0;
    chk("mr_drain", dv_a1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
